// File: rtl/pe_mac_sat_if.sv
// Operand, psum and control bundle of one systolic-array processing element.
// The PE takes the slave side; its driver (neighbour PE or test harness) takes the master side.
interface pe_mac_sat_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 16
);
  logic                  clear;
  logic                  drain_start;
  logic [DATA_WIDTH-1:0] top_in;
  logic                  top_valid;
  logic [DATA_WIDTH-1:0] left_in;
  logic                  left_valid;
  logic [OUT_WIDTH-1:0]  psum_in;
  logic                  psum_in_valid;
  logic [DATA_WIDTH-1:0] bottom_out;
  logic                  bottom_valid;
  logic [DATA_WIDTH-1:0] right_out;
  logic                  right_valid;
  logic [OUT_WIDTH-1:0]  psum_out;
  logic                  psum_out_valid;
  logic                  busy;
  logic                  overflow;

  modport master (
    output clear, drain_start, top_in, top_valid, left_in, left_valid, psum_in, psum_in_valid,
    input  bottom_out, bottom_valid, right_out, right_valid, psum_out, psum_out_valid, busy,
           overflow
  );

  modport slave (
    input  clear, drain_start, top_in, top_valid, left_in, left_valid, psum_in, psum_in_valid,
    output bottom_out, bottom_valid, right_out, right_valid, psum_out, psum_out_valid, busy,
           overflow
  );
endinterface

// File: rtl/pe_mac_sat.sv
// Output-stationary MAC processing element: forwards operands, accumulates products,
// then drains its saturated result followed by DEPTH upstream psum words down the column.
module pe_mac_sat #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter bit          SIGNED     = 1'b1,
  parameter int unsigned DEPTH      = 3
) (
  input logic        clk,
  input logic        rst,
  pe_mac_sat_if.slave bus
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned CNT_WIDTH  = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
  localparam int unsigned HEAD_WIDTH = ACC_WIDTH - OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                 state, state_d;
  logic [ACC_WIDTH-1:0]   acc, acc_d;
  logic [ACC_WIDTH-1:0]   product, mac_sum, load_val;
  logic [CNT_WIDTH-1:0]   cnt, cnt_d;
  logic [OUT_WIDTH-1:0]   psum_d, sat_val;
  logic                   psum_valid_d, overflow_d, busy_d, sat_ovf, fire;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic [PROD_WIDTH-1:0]  prod_u;

  assign fire   = bus.top_valid & bus.left_valid;
  assign prod_s = PROD_WIDTH'($signed(bus.top_in)) * PROD_WIDTH'($signed(bus.left_in));
  assign prod_u = PROD_WIDTH'(bus.top_in) * PROD_WIDTH'(bus.left_in);
  assign product = SIGNED ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);
  assign mac_sum = acc + product;
  // A drain issued in the same cycle as a fire includes that last product.
  assign load_val = (state == ACCUM && fire) ? mac_sum : acc;

  generate
    if (HEAD_WIDTH == 0) begin : g_nosat
      assign sat_val = load_val;
      assign sat_ovf = 1'b0;
    end else if (SIGNED) begin : g_ssat
      logic [HEAD_WIDTH:0] head;
      // Fits iff all bits from the output sign bit upward agree.
      assign head    = load_val[ACC_WIDTH-1:OUT_WIDTH-1];
      assign sat_ovf = !((&head) || (~|head));
      assign sat_val = !sat_ovf ? load_val[OUT_WIDTH-1:0] :
                       load_val[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                               {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin : g_usat
      assign sat_ovf = |load_val[ACC_WIDTH-1:OUT_WIDTH];
      assign sat_val = sat_ovf ? {OUT_WIDTH{1'b1}} : load_val[OUT_WIDTH-1:0];
    end
  endgenerate

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    acc_d        = acc;
    cnt_d        = cnt;
    psum_d       = bus.psum_out;
    psum_valid_d = 1'b0;
    overflow_d   = bus.overflow;
    if (bus.clear) begin
      state_d    = ACCUM;
      acc_d      = fire ? product : '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (bus.drain_start) begin
            state_d      = DRAIN;
            acc_d        = load_val;
            cnt_d        = '0;
            psum_d       = sat_val;
            psum_valid_d = 1'b1;
            overflow_d   = bus.overflow | sat_ovf;
          end else if (state == ACCUM && fire) begin
            acc_d = mac_sum;
          end
        end
        DRAIN: begin
          if (cnt == CNT_WIDTH'(DEPTH)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            psum_d       = bus.psum_in;
            psum_valid_d = bus.psum_in_valid;
            cnt_d        = cnt + CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      acc                <= '0;
      cnt                <= '0;
      bus.bottom_out     <= '0;
      bus.bottom_valid   <= 1'b0;
      bus.right_out      <= '0;
      bus.right_valid    <= 1'b0;
      bus.psum_out       <= '0;
      bus.psum_out_valid <= 1'b0;
      bus.busy           <= 1'b0;
      bus.overflow       <= 1'b0;
    end else begin
      state              <= state_d;
      acc                <= acc_d;
      cnt                <= cnt_d;
      bus.bottom_out     <= bus.top_in;
      bus.bottom_valid   <= bus.top_valid;
      bus.right_out      <= bus.left_in;
      bus.right_valid    <= bus.left_valid;
      bus.psum_out       <= psum_d;
      bus.psum_out_valid <= psum_valid_d;
      bus.busy           <= busy_d;
      bus.overflow       <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pe_mac_sat.sv
// Bench for pe_mac_sat: a signed and an unsigned instance share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed result checks.
module tb_pe_mac_sat;

  localparam int unsigned DEPTH = 3;

  logic clk, rst;
  logic clr, ds, tv, lv, piv;
  logic [7:0]  ti, li;
  logic [15:0] pi;

  int compared, mismatched;

  pe_mac_sat_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) bus_s ();
  pe_mac_sat_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) bus_u ();

  assign bus_s.clear = clr;  assign bus_s.drain_start = ds;
  assign bus_s.top_in = ti;  assign bus_s.top_valid = tv;
  assign bus_s.left_in = li; assign bus_s.left_valid = lv;
  assign bus_s.psum_in = pi; assign bus_s.psum_in_valid = piv;
  assign bus_u.clear = clr;  assign bus_u.drain_start = ds;
  assign bus_u.top_in = ti;  assign bus_u.top_valid = tv;
  assign bus_u.left_in = li; assign bus_u.left_valid = lv;
  assign bus_u.psum_in = pi; assign bus_u.psum_in_valid = piv;

  pe_mac_sat #(.DATA_WIDTH(8), .ACC_WIDTH(24), .OUT_WIDTH(16), .SIGNED(1'b1), .DEPTH(DEPTH))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));
  pe_mac_sat #(.DATA_WIDTH(8), .ACC_WIDTH(24), .OUT_WIDTH(16), .SIGNED(1'b0), .DEPTH(DEPTH))
    dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, index 0 = signed instance, 1 = unsigned instance.
  localparam longint ACC_MOD = longint'(1) << 24;
  longint m_acc [2];
  bit     m_on  [2];
  int     m_left[2];
  longint m_pout[2];
  bit     m_pv  [2];
  bit     m_ovf [2];
  longint m_bo, m_ro;
  bit     m_bv, m_rv;

  task automatic check(input string tag, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint m_product(input bit sg, input logic [7:0] a, input logic [7:0] b);
    if (sg) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  function automatic longint m_sat(input bit sg, input longint acc, output bit ovf);
    longint v, lo, hi;
    v   = acc;
    if (sg && v >= ACC_MOD / 2) v = v - ACC_MOD;
    lo  = sg ? -32768 : 0;
    hi  = sg ? 32767 : 65535;
    ovf = 1'b0;
    if (v > hi) begin v = hi; ovf = 1'b1; end
    else if (v < lo) begin v = lo; ovf = 1'b1; end
    return v & 64'hFFFF;
  endfunction

  task automatic model_step();
    bit fire, o;
    longint p, v;
    fire = tv & lv;
    if (rst) begin
      m_bo = 0; m_bv = 0; m_ro = 0; m_rv = 0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_on[k] = 0; m_left[k] = -1; m_pout[k] = 0; m_pv[k] = 0; m_ovf[k] = 0;
      end
      return;
    end
    m_bo = ti; m_bv = tv; m_ro = li; m_rv = lv;
    for (int k = 0; k < 2; k++) begin
      p = m_product(k == 0, ti, li);
      m_pv[k] = 1'b0;
      if (clr) begin
        m_acc[k] = fire ? (p & (ACC_MOD - 1)) : 0;
        m_ovf[k] = 0; m_left[k] = -1; m_on[k] = 1;
      end else if (m_left[k] >= 0) begin
        if (m_left[k] == 0) begin
          m_left[k] = -1; m_on[k] = 0;
        end else begin
          m_pout[k] = pi; m_pv[k] = piv; m_left[k]--;
        end
      end else if (ds) begin
        v = (m_on[k] && fire) ? ((m_acc[k] + p) & (ACC_MOD - 1)) : m_acc[k];
        m_acc[k]  = v;
        m_pout[k] = m_sat(k == 0, v, o);
        m_ovf[k]  = m_ovf[k] | o;
        m_pv[k]   = 1'b1;
        m_left[k] = DEPTH;
        m_on[k]   = 0;
      end else if (m_on[k] && fire) begin
        m_acc[k] = (m_acc[k] + p) & (ACC_MOD - 1);
      end
    end
  endtask

  task automatic compare_dut(input int k, input logic [7:0] bo, input logic bv,
                             input logic [7:0] ro, input logic rv, input logic [15:0] po,
                             input logic pv, input logic bz, input logic ov);
    string n;
    n = (k == 0) ? "s" : "u";
    check({n, ".bottom_out"}, bo, m_bo);
    check({n, ".bottom_valid"}, bv, m_bv);
    check({n, ".right_out"}, ro, m_ro);
    check({n, ".right_valid"}, rv, m_rv);
    check({n, ".psum_out"}, po, m_pout[k]);
    check({n, ".psum_out_valid"}, pv, m_pv[k]);
    check({n, ".busy"}, bz, m_left[k] >= 0);
    check({n, ".overflow"}, ov, m_ovf[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_dut(0, bus_s.bottom_out, bus_s.bottom_valid, bus_s.right_out, bus_s.right_valid,
                bus_s.psum_out, bus_s.psum_out_valid, bus_s.busy, bus_s.overflow);
    compare_dut(1, bus_u.bottom_out, bus_u.bottom_valid, bus_u.right_out, bus_u.right_valid,
                bus_u.psum_out, bus_u.psum_out_valid, bus_u.busy, bus_u.overflow);
  endtask

  task automatic step_in(input bit c, input bit d, input logic [7:0] t, input bit tvv,
                         input logic [7:0] l, input bit lvv, input logic [15:0] p, input bit pv);
    clr = c; ds = d; ti = t; tv = tvv; li = l; lv = lvv; pi = p; piv = pv;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      step_in(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
              1'($urandom), 16'($urandom), 1'($urandom));
    check("reset.psum_out", bus_s.psum_out, 0);
    check("reset.busy", bus_s.busy, 0);
    check("reset.bottom_valid", bus_u.bottom_valid, 0);
    rst = 1'b0;

    // Fire straight after reset lands in IDLE and must not accumulate.
    step_in(0, 0, 8'd5, 1, 8'd5, 1, 16'h0, 0);
    step_in(0, 1, 8'd0, 0, 8'd0, 0, 16'h0, 0);
    check("no_acc_after_reset", bus_s.psum_out, 16'h0000);
    check("no_acc_valid", bus_s.psum_out_valid, 1);
    idle(DEPTH + 1);

    // Signed MAC: 4 x (-3 * 5) = -60.
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step_in(0, 0, 8'hFD, 1, 8'd5, 1, 16'h0, 0);
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    check("signed_mac", bus_s.psum_out, 16'hFFC4);
    check("signed_mac_ovf", bus_s.overflow, 0);
    idle(1);
    check("signed_mac_one_cycle", bus_s.psum_out_valid, 0);
    idle(DEPTH);

    // Positive saturation.
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) step_in(0, 0, 8'd127, 1, 8'd127, 1, 16'h0, 0);
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    check("sat_hi", bus_s.psum_out, 16'h7FFF);
    check("sat_ovf", bus_s.overflow, 1);
    idle(DEPTH + 1);
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    check("clear_ovf", bus_s.overflow, 0);

    // Drain chain pass-through of three upstream words.
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0011, 1);
    check("chain0", bus_s.psum_out, 16'h0011);
    check("chain0_v", bus_s.psum_out_valid, 1);
    step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0022, 0);
    check("chain1", bus_s.psum_out, 16'h0022);
    check("chain1_v", bus_s.psum_out_valid, 0);
    step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0033, 1);
    check("chain2", bus_s.psum_out, 16'h0033);
    check("chain2_busy", bus_s.busy, 1);
    step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0044, 1);
    check("chain_end_v", bus_s.psum_out_valid, 0);
    check("chain_end_hold", bus_s.psum_out, 16'h0033);
    check("chain_end_busy", bus_s.busy, 0);

    // Clear mid-drain with a simultaneous fire seeds the accumulator with 2*4.
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(0, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(1, 0, 8'd2, 1, 8'd4, 1, 16'h0, 0);
    check("abort_busy", bus_s.busy, 0);
    step_in(0, 0, 8'd3, 1, 8'd3, 1, 16'h0, 0);
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    check("abort_result", bus_s.psum_out, 16'h0011);
    idle(DEPTH + 1);

    // Unsigned instance: 255*255 fits, two of them clamp.
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(0, 0, 8'hFF, 1, 8'hFF, 1, 16'h0, 0);
    step_in(0, 1, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    check("u_one", bus_u.psum_out, 16'hFE01);
    check("u_one_ovf", bus_u.overflow, 0);
    idle(DEPTH + 1);
    step_in(1, 0, 8'h00, 0, 8'h00, 0, 16'h0, 0);
    step_in(0, 0, 8'hFF, 1, 8'hFF, 1, 16'h0, 0);
    step_in(0, 1, 8'hFF, 1, 8'hFF, 1, 16'h0, 0);
    check("u_sat", bus_u.psum_out, 16'hFFFF);
    check("u_sat_ovf", bus_u.overflow, 1);
    idle(DEPTH + 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step_in($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
              $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
              16'($urandom), 1'($urandom));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
